// File: rtl/dst7_mcm_pipe_if.sv
// Beat bus for the DST-7 MCM stage: sample/mode/last in, 20 lane products out.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs; master sources beats, slave is the MCM block.
`timescale 1ns/1ps
interface dst7_mcm_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 23,
  parameter int NLANE = 20
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [IN_W-1:0]    in_x;
  logic [1:0]                in_mode;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [NLANE*OUT_W-1:0]    out_y;
  logic [1:0]                out_mode;
  logic                      out_last;

  modport master (
    output in_valid, in_x, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_mode, out_last
  );

  modport slave (
    input  in_valid, in_x, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_y, out_mode, out_last
  );
endinterface

// File: rtl/dst7_mcm_pipe.sv
// Multiplierless multiple-constant multiply of one sample by a selectable DST-7 coefficient set.
// Latency: 2 cycles (S1 base terms, S2 lane products), one beat per cycle sustained.
// Backpressure: 2-entry stallable pipe; in_ready = !s1_valid || s2 loading, no path from in_valid.
`timescale 1ns/1ps
module dst7_mcm_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 23,
  parameter int NLANE = 20
) (
  input logic            clk,
  input logic            rst_n,
  dst7_mcm_pipe_if.slave bus
);

  generate
    if (IN_W < 2) begin : g_bad_in_w
      $error("dst7_mcm_pipe: IN_W must be at least 2");
    end
    if (OUT_W < IN_W + 7) begin : g_bad_out_w
      $error("dst7_mcm_pipe: OUT_W must be at least IN_W+7");
    end
    if (NLANE != 20) begin : g_bad_nlane
      $error("dst7_mcm_pipe: NLANE must be 20");
    end
  endgenerate

  // Largest constant is 86 < 2^7, so IN_W+7 bits hold every partial term exactly.
  localparam int IW = IN_W + 7;

  typedef logic signed [IW-1:0]    term_t;
  typedef logic signed [OUT_W-1:0] lane_t;

  typedef struct packed {
    logic [1:0] mode;
    logic       last;
  } meta_t;

  // Odd multiples of X shared by all three coefficient sets.
  typedef struct packed {
    term_t x1;  term_t x3;  term_t x5;  term_t x7;
    term_t x9;  term_t x11; term_t x13; term_t x15;
    term_t x17; term_t x19; term_t x21; term_t x23;
    term_t x25; term_t x27; term_t x29; term_t x31;
  } terms_t;

  logic                   s1_valid;
  meta_t                  s1_meta;
  terms_t                 s1_terms;
  logic                   s2_valid;
  meta_t                  s2_meta;
  logic [NLANE*OUT_W-1:0] s2_y;

  logic                   s2_load;
  logic                   in_ready_c;
  logic                   in_fire;
  term_t                  xe;
  terms_t                 terms_c;
  term_t                  prod [NLANE];
  logic [NLANE*OUT_W-1:0] y_nxt;

  assign s2_load    = !s2_valid || bus.out_ready;
  assign in_ready_c = !s1_valid || s2_load;
  assign in_fire    = bus.in_valid && in_ready_c;
  assign xe         = {{7{bus.in_x[IN_W-1]}}, bus.in_x};

  // Build the shared odd multiples from X with at most two adders in series.
  always_comb begin
    terms_c     = '0;
    terms_c.x1  = xe;
    terms_c.x3  = (xe <<< 1) + xe;
    terms_c.x5  = (xe <<< 2) + xe;
    terms_c.x7  = (xe <<< 3) - xe;
    terms_c.x9  = (xe <<< 3) + xe;
    terms_c.x11 = (xe <<< 3) + terms_c.x3;
    terms_c.x13 = (xe <<< 3) + terms_c.x5;
    terms_c.x15 = (xe <<< 4) - xe;
    terms_c.x17 = (xe <<< 4) + xe;
    terms_c.x19 = (xe <<< 4) + terms_c.x3;
    terms_c.x21 = (xe <<< 4) + terms_c.x5;
    terms_c.x23 = (xe <<< 4) + terms_c.x7;
    terms_c.x25 = (xe <<< 4) + terms_c.x9;
    terms_c.x27 = (xe <<< 5) - terms_c.x5;
    terms_c.x29 = (xe <<< 5) - terms_c.x3;
    terms_c.x31 = (xe <<< 5) - xe;
  end

  // S1 occupancy: refills whenever the stage is free to advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
    end
  end

  // S1 payload: captured only on an accepted beat, otherwise held for the stall.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_meta  <= '{mode: bus.in_mode, last: bus.in_last};
      s1_terms <= terms_c;
    end
  end

  // Per-lane products: each constant is an odd base term shifted, or base term plus a power of two.
  always_comb begin
    for (int k = 0; k < NLANE; k++) begin
      prod[k] = '0;
    end
    case (s1_meta.mode)
      2'd0: begin
        prod[0]  = s1_terms.x3  <<< 1;
        prod[1]  = s1_terms.x9;
        prod[2]  = s1_terms.x11;
        prod[3]  = s1_terms.x3  <<< 2;
        prod[4]  = s1_terms.x13;
        prod[5]  = s1_terms.x15;
        prod[6]  = s1_terms.x17;
        prod[7]  = s1_terms.x19;
        prod[8]  = s1_terms.x5  <<< 2;
        prod[9]  = s1_terms.x21;
        prod[10] = s1_terms.x11 <<< 1;
        prod[11] = s1_terms.x23;
        prod[12] = s1_terms.x3  <<< 3;
        prod[13] = s1_terms.x25;
        prod[14] = s1_terms.x13 <<< 1;
        prod[15] = s1_terms.x27;
        prod[16] = s1_terms.x7  <<< 2;
        prod[17] = s1_terms.x29;
        prod[18] = s1_terms.x15 <<< 1;
        prod[19] = s1_terms.x31;
      end
      2'd1: begin
        prod[0] = s1_terms.x17;
        prod[1] = s1_terms.x1 <<< 5;
        prod[2] = s1_terms.x23 <<< 1;
        prod[3] = s1_terms.x15 <<< 2;
        prod[4] = (s1_terms.x1 <<< 6) + s1_terms.x7;
        prod[5] = ((s1_terms.x1 <<< 5) + s1_terms.x7) <<< 1;
        prod[6] = (s1_terms.x1 <<< 6) + s1_terms.x21;
        prod[7] = ((s1_terms.x1 <<< 5) + s1_terms.x11) <<< 1;
      end
      2'd2: begin
        prod[0] = s1_terms.x29;
        prod[1] = (s1_terms.x1 <<< 6) - s1_terms.x9;
        prod[2] = ((s1_terms.x1 <<< 5) + s1_terms.x5) <<< 1;
        prod[3] = s1_terms.x21 <<< 2;
      end
      default: begin
      end
    endcase
  end

  // Sign-extend each lane product into its OUT_W slot of the output bus.
  always_comb begin
    y_nxt = '0;
    for (int k = 0; k < NLANE; k++) begin
      y_nxt[k*OUT_W +: OUT_W] = lane_t'(prod[k]);
    end
  end

  // S2 holds the presented beat; it only changes when empty or taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_meta  <= '0;
      s2_y     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_meta <= s1_meta;
        s2_y    <= y_nxt;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid;
  assign bus.out_y     = s2_y;
  assign bus.out_mode  = s2_meta.mode;
  assign bus.out_last  = s2_meta.last;

endmodule

// File: tb/tb_dst7_mcm_pipe.sv
// Bench for dst7_mcm_pipe: directed constants/corners, throughput, backpressure, random stall, reset.
// Latency: expects transfers two edges after acceptance when the output is never stalled.
// Backpressure: drives out_ready directly or randomly; scoreboard checks order and hold stability.
`timescale 1ns/1ps
module tb_dst7_mcm_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 23;
  localparam int NLANE = 20;
  localparam int YW    = NLANE * OUT_W;

  localparam int COEF [3][20] = '{
    '{6, 9, 11, 12, 13, 15, 17, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31},
    '{17, 32, 46, 60, 71, 78, 85, 86, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{29, 55, 74, 84, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
  };

  typedef struct {
    logic [YW-1:0] y;
    logic [1:0]    mode;
    logic          last;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   xfer_cnt;
  bit   rnd_rdy;
  bit   rst_seen;
  exp_t sbq [$];

  dst7_mcm_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .NLANE(NLANE)) bus ();

  dst7_mcm_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .NLANE(NLANE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Exact products from the coefficient table; reserved mode gives all-zero lanes.
  function automatic logic [YW-1:0] model_y(input int x, input int mode);
    logic [YW-1:0] r;
    longint        p;
    r = '0;
    if (mode < 3) begin
      for (int k = 0; k < NLANE; k++) begin
        p = longint'(x) * longint'(COEF[mode][k]);
        r[k*OUT_W +: OUT_W] = p[OUT_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic longint lane(input logic [YW-1:0] y, input int k);
    logic signed [OUT_W-1:0] v;
    v = y[k*OUT_W +: OUT_W];
    return longint'(v);
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input int x, input int mode, input bit last, input bit chk_lat);
    exp_t e;
    e.y       = model_y(x, mode);
    e.mode    = mode[1:0];
    e.last    = last;
    e.acc_cyc = cyc;
    e.chk_lat = chk_lat;
    sbq.push_back(e);
  endtask

  // Present one beat and hold it until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input int x, input int mode, input bit last, input bit chk_lat, output int waits);
    bit done;
    bus.in_valid = 1'b1;
    bus.in_x     = IN_W'(x);
    bus.in_mode  = mode[1:0];
    bus.in_last  = last;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(x, mode, last, chk_lat);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 500) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout x=%0d mode=%0d", x, mode);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", sbq.size(), 0);
  endtask

  task automatic wait_out(output logic [YW-1:0] y);
    int n;
    y = '0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.out_valid) begin
        y = bus.out_y;
        n = 100;
      end else begin
        n++;
      end
    end
    if (n != 100) begin
      checks++;
      errors++;
      $display("FAIL output_timeout got none expected one beat");
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_x();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Monitor: pops the scoreboard on each transfer and checks output hold during stalls.
  initial begin
    logic [YW-1:0] prev_y;
    logic [1:0]    prev_mode;
    logic          prev_last;
    bit            prev_hold;
    exp_t          e;
    prev_hold = 1'b0;
    prev_y    = '0;
    prev_mode = '0;
    prev_last = 1'b0;
    xfer_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || rst_seen) begin
        prev_hold = 1'b0;
        rst_seen  = 1'b0;
      end
      if (rst_n) begin
        if (prev_hold) begin
          checks++;
          if (!bus.out_valid || bus.out_y !== prev_y || bus.out_mode !== prev_mode || bus.out_last !== prev_last) begin
            errors++;
            $display("FAIL hold_stable got valid=%0b mode=%0d last=%0d expected held mode=%0d last=%0d",
                     bus.out_valid, bus.out_mode, bus.out_last, prev_mode, prev_last);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got mode=%0d last=%0d expected no beat", bus.out_mode, bus.out_last);
          end else begin
            e = sbq.pop_front();
            xfer_cnt++;
            if (bus.out_y !== e.y || bus.out_mode !== e.mode || bus.out_last !== e.last) begin
              errors++;
              $display("FAIL beat got y=%h mode=%0d last=%0d expected y=%h mode=%0d last=%0d",
                       bus.out_y, bus.out_mode, bus.out_last, e.y, e.mode, e.last);
            end
            if (e.chk_lat) begin
              chk("latency", cyc - e.acc_cyc, 2);
            end
          end
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_y    = bus.out_y;
        prev_mode = bus.out_mode;
        prev_last = bus.out_last;
      end
    end
  end

  // Random downstream readiness while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [YW-1:0] y;
    int            w;
    int            stalls;
    int            base;
    int            acc;
    int            bx [3];
    int            bm [3];
    bit            bl [3];

    checks        = 0;
    errors        = 0;
    rnd_rdy       = 1'b0;
    rst_seen      = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_mode   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_y_nonzero", (bus.out_y != '0) ? 1 : 0, 0);
    chk("rst_out_mode", bus.out_mode, 0);
    chk("rst_out_last", bus.out_last, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", bus.in_ready, 1);

    // Constant sweep: X = 1 exposes each coefficient list directly
    bus.out_ready = 1'b1;
    for (int m = 0; m < 4; m++) send(1, m, m[0], 1'b1, w);
    idle();
    drain();

    // Signed corners against hand-derived products
    send(-32768, 1, 1'b1, 1'b1, w);
    idle();
    wait_out(y);
    chk("neg_full_m1_lane7", lane(y, 7), -2818048);
    chk("neg_full_m1_lane0", lane(y, 0), -557056);
    send(32767, 0, 1'b0, 1'b1, w);
    idle();
    wait_out(y);
    chk("pos_full_m0_lane19", lane(y, 19), 1015777);
    send(-3, 2, 1'b1, 1'b1, w);
    idle();
    wait_out(y);
    chk("m2_lane0", lane(y, 0), -87);
    chk("m2_lane1", lane(y, 1), -165);
    chk("m2_lane2", lane(y, 2), -222);
    chk("m2_lane3", lane(y, 3), -252);
    chk("m2_lane4_unused", lane(y, 4), 0);
    chk("m2_lane19_unused", lane(y, 19), 0);
    drain();

    // Throughput: 64 back-to-back beats must all transfer within 64 consecutive edges
    base   = xfer_cnt;
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      send(rnd_x(), int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), 1'b1, w);
      stalls += w;
    end
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("tput_input_stalls", stalls, 0);
    chk("tput_outputs", xfer_cnt - base, 64);
    drain();

    // Backpressure: three beats offered with output blocked for five cycles
    bus.out_ready = 1'b0;
    bx = '{1234, -777, 32767};
    bm = '{0, 2, 1};
    bl = '{1'b1, 1'b0, 1'b1};
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = IN_W'(bx[0]);
    bus.in_mode  = bm[0][1:0];
    bus.in_last  = bl[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.in_ready && acc < 3) begin
        push_exp(bx[acc], bm[acc], bl[acc], 1'b0);
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc < 3) begin
        bus.in_x    = IN_W'(bx[acc]);
        bus.in_mode = bm[acc][1:0];
        bus.in_last = bl[acc];
      end
    end
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_out_valid_held", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    send(bx[2], bm[2], bl[2], 1'b0, w);
    idle();
    drain();

    // Random stall: random input gaps and 50% downstream readiness
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        idle();
        @(posedge clk);
        #1;
      end
      send(rnd_x(), int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), 1'b0, w);
    end
    idle();
    rnd_rdy = 1'b0;
    drain();

    // Reset while two beats are held
    bus.out_ready = 1'b0;
    send(555, 0, 1'b1, 1'b0, w);
    send(-999, 1, 1'b0, 1'b0, w);
    idle();
    chk("held_in_ready_low", bus.in_ready, 0);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    rst_seen = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_y_nonzero", (bus.out_y != '0) ? 1 : 0, 0);
    chk("mid_rst_out_mode", bus.out_mode, 0);
    chk("mid_rst_out_last", bus.out_last, 0);
    sbq.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    send(-12345, 2, 1'b1, 1'b1, w);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
